hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised successor to the single-entry load-use hazard detector. It keeps a per-register countdown scoreboard of in-flight writes with configurable load and writeback latencies, and gates the ID stage. It also suppresses hazards on register x0 and on unused operands, honours an ID-stage flush, and counts stall cycles. It sits between the IF/ID register and the ID/EX register and drives PC write enable, IF/ID write enable and the bubble-insert mux select.

## Interface
- ADDRESS_LEN, 5, register address width; NUM_REGS = 2**ADDRESS_LEN
- LOAD_LAT, 1, cycles after issue before a load result can be consumed (1..7)
- WB_LAT, 3, cycles after issue before any result reaches the register file (LOAD_LAT..7)
- STALL_CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  IF/ID holds a valid instruction
- rd_addr_1_if_id  in  ADDRESS_LEN  source 1 address
- rd_addr_2_if_id  in  ADDRESS_LEN  source 2 address
- rs1_used, rs2_used  in  1 each  operand actually read
- wr_addr_if_id  in  ADDRESS_LEN  destination address
- reg_write_if_id  in  1  instruction writes a register
- mem_read_if_id  in  1  instruction is a load
- flush  in  1  kill the IF/ID instruction this cycle (branch redirect)
- pc_write  out  1  0 = hold PC
- if_id_write  out  1  0 = hold IF/ID
- mux_sel  out  1  0 = insert bubble into ID/EX
- issue  out  1  instruction leaves ID this cycle
- busy  out  1  any scoreboard counter nonzero
- stall_count  out  STALL_CNT_W  saturating count of stall cycles

## Operation
- State: cnt[r], 3 bits, one per register; cnt[0] is never written and always reads 0.
- hazard (combinational) = id_valid & ~flush & ((rs1_used & rd_addr_1_if_id != 0 & cnt[rd_addr_1_if_id] != 0) | (rs2_used & rd_addr_2_if_id != 0 & cnt[rd_addr_2_if_id] != 0)).
- On hazard, pc_write, if_id_write and mux_sel are all 0. Otherwise all three are 1.
- issue = id_valid & ~flush & ~hazard.
- Each cycle, every nonzero cnt decrements by 1.
- If issue & reg_write_if_id & wr_addr_if_id != 0, cnt[wr_addr_if_id] loads max(L, cnt - 1). Latency L is defined under Configuration. max() preserves an older, longer-latency write (WAW).
- flush: no issue and no stall; the scoreboard still decrements.
- busy = OR of all cnt.
- stall_count increments on every hazard cycle and saturates at all-ones.

## Timing
- Outputs react combinationally to ID inputs in the same cycle. Scoreboard updates land at the next rising edge.
- Load-use with LOAD_LAT=1: one bubble. Dependent instruction in ID the cycle after the load issues sees cnt=1 and stalls; the following cycle it issues.
- Stall length for a dependent instruction arriving k cycles after the producer issues = max(0, L - k + 1) cycles.
- Reset (asynchronous, any time including mid-stall): all cnt = 0, stall_count = 0, busy = 0. pc_write, if_id_write and mux_sel are therefore 1 and issue follows id_valid & ~flush.
- Simultaneous issue write and read of the same register by the next instruction: the new value is visible the following cycle. There is no same-cycle self-hazard.
- stall_count wraps never; it holds at 2**STALL_CNT_W - 1.

## Configuration
- HAZ_FORWARDING_EN defined: the pipeline has EX/MEM forwarding. L = LOAD_LAT for loads; non-load writes are not tracked (L = 0, no counter load).
- HAZ_FORWARDING_EN undefined: no forwarding. L = WB_LAT for every register write, loads included.

## Test plan
- Forwarding on, LOAD_LAT=1: lw x5 issued, then add x6,x5,x1 in ID next cycle -> exactly one cycle with pc_write=if_id_write=mux_sel=0, then issue=1; stall_count=1.
- Forwarding off, WB_LAT=3: add x5 issued, then sub x7,x5,x2 next cycle -> three stall cycles; same pair with rs2_used=0 and x5 only on rs2 -> zero stalls.
- Write to x0 followed by a reader of x0 -> no stall, busy stays 0; reader of x5 with rs1_used=0 -> no stall.
- WAW, forwarding off: lw x5 (L=3) then, two cycles later, add x5 (L=3) -> cnt[x5] reloads to 3; a subsequent reader stalls until cnt=0.
- flush asserted while a hazard exists -> outputs 1, issue=0, stall_count unchanged; rst_n pulsed low mid-stall -> outputs 1 immediately, busy=0, stall_count=0.
- Force 2**STALL_CNT_W + 5 stall cycles (STALL_CNT_W=4) -> stall_count holds at 15.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard that stalls the ID stage until in-flight results can be consumed.
// Optional macro HAZ_FORWARDING_EN: with EX/MEM forwarding only loads are tracked (LOAD_LAT).
module hazard_scoreboard #(
  parameter int ADDRESS_LEN = 5,
  parameter int LOAD_LAT    = 1,
  parameter int WB_LAT      = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [ADDRESS_LEN-1:0] rd_addr_1_if_id,
  input  logic [ADDRESS_LEN-1:0] rd_addr_2_if_id,
  input  logic                   rs1_used,
  input  logic                   rs2_used,
  input  logic [ADDRESS_LEN-1:0] wr_addr_if_id,
  input  logic                   reg_write_if_id,
  input  logic                   mem_read_if_id,
  input  logic                   flush,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   mux_sel,
  output logic                   issue,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int NUM_REGS = 2 ** ADDRESS_LEN;

  logic [2:0] cnt_reg [NUM_REGS];
  logic [2:0] lat;
  logic       hazard;
  logic       track_write;

`ifdef HAZ_FORWARDING_EN
  // ALU results are forwarded, so only a load's result needs waiting for.
  assign lat = mem_read_if_id ? 3'(LOAD_LAT) : 3'd0;
`else
  assign lat = mem_read_if_id ? 3'(WB_LAT) : 3'(WB_LAT);
`endif

  assign hazard = id_valid & ~flush &
                  ((rs1_used & (rd_addr_1_if_id != '0) & (cnt_reg[rd_addr_1_if_id] != 3'd0)) |
                   (rs2_used & (rd_addr_2_if_id != '0) & (cnt_reg[rd_addr_2_if_id] != 3'd0)));

  assign pc_write    = ~hazard;
  assign if_id_write = ~hazard;
  assign mux_sel     = ~hazard;
  assign issue       = id_valid & ~flush & ~hazard;

  assign track_write = issue & reg_write_if_id & (wr_addr_if_id != '0);

  always_comb begin
    busy = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy = busy | (cnt_reg[r] != 3'd0);
    end
  end

  // Entry 0 is reset and never written, so x0 never produces a hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_reg[r] <= 3'd0;
      end
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        logic [2:0] dec;
        dec = (cnt_reg[r] != 3'd0) ? cnt_reg[r] - 3'd1 : 3'd0;
        // Keep the longer of an older pending write and the new one (WAW).
        if (track_write && (wr_addr_if_id == ADDRESS_LEN'(r)) && (lat > dec)) begin
          cnt_reg[r] <= lat;
        end else begin
          cnt_reg[r] <= dec;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (hazard && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: hand-written vector table, corner sequences and random stimulus
// compared against a ready-time model of the scoreboard.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] rd_addr_1_if_id, rd_addr_2_if_id, wr_addr_if_id;
  logic       rs1_used, rs2_used, reg_write_if_id, mem_read_if_id, flush;
  logic       pc_write, if_id_write, mux_sel, issue, busy;
  logic [3:0] stall_count;

  always #5 clk = ~clk;

  hazard_scoreboard #(.ADDRESS_LEN(5), .LOAD_LAT(1), .WB_LAT(3), .STALL_CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .rd_addr_1_if_id(rd_addr_1_if_id), .rd_addr_2_if_id(rd_addr_2_if_id),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .wr_addr_if_id(wr_addr_if_id),
    .reg_write_if_id(reg_write_if_id), .mem_read_if_id(mem_read_if_id), .flush(flush),
    .pc_write(pc_write), .if_id_write(if_id_write), .mux_sel(mux_sel),
    .issue(issue), .busy(busy), .stall_count(stall_count)
  );

  int errors = 0;
  int checks = 0;

  // Model: absolute cycle at which each register becomes readable.
  int now = 0;
  int ready [32];
  int sc_m = 0;

  typedef struct {
    bit v; bit [4:0] a1; bit [4:0] a2; bit u1; bit u2;
    bit [4:0] w; bit rw; bit mr; bit fl;
    int haz; int bsy; int sc;
  } vec_t;
  vec_t tab[$];

  function automatic int lat_of(bit mr);
`ifdef HAZ_FORWARDING_EN
    return mr ? 1 : 0;
`else
    return 3;
`endif
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) ready[r] = 0;
    sc_m = 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, now);
    end
  endtask

  function automatic vec_t mk(bit v, bit [4:0] a1, bit [4:0] a2, bit u1, bit u2, bit [4:0] w,
                              bit rw, bit mr, bit fl, int haz, int bsy, int sc);
    vec_t t;
    t.v = v; t.a1 = a1; t.a2 = a2; t.u1 = u1; t.u2 = u2; t.w = w;
    t.rw = rw; t.mr = mr; t.fl = fl; t.haz = haz; t.bsy = bsy; t.sc = sc;
    return t;
  endfunction

  // One ID-stage cycle: drive, compare against model (and table if t_haz >= 0), clock.
  task automatic apply(input vec_t t);
    bit haz_m, busy_m, iss_m;
    int l;
    id_valid = t.v; rd_addr_1_if_id = t.a1; rd_addr_2_if_id = t.a2;
    rs1_used = t.u1; rs2_used = t.u2; wr_addr_if_id = t.w;
    reg_write_if_id = t.rw; mem_read_if_id = t.mr; flush = t.fl;
    #2;
    haz_m = t.v && !t.fl && ((t.u1 && t.a1 != 0 && ready[t.a1] > now) ||
                             (t.u2 && t.a2 != 0 && ready[t.a2] > now));
    iss_m = t.v && !t.fl && !haz_m;
    busy_m = 1'b0;
    for (int r = 1; r < 32; r++) if (ready[r] > now) busy_m = 1'b1;
    chk("pc_write", pc_write, !haz_m);
    chk("if_id_write", if_id_write, !haz_m);
    chk("mux_sel", mux_sel, !haz_m);
    chk("issue", issue, iss_m);
    chk("busy", busy, busy_m);
    chk("stall_count", stall_count, sc_m);
    if (t.haz >= 0) begin
      chk("tab_stall", !pc_write, t.haz);
      chk("tab_issue", issue, t.v && !t.fl && (t.haz == 0));
      chk("tab_busy", busy, t.bsy);
      chk("tab_stall_count", stall_count, t.sc);
    end
    $display("cyc %0d v=%0d rs1=%0d/%0d rs2=%0d/%0d wr=%0d rw=%0d ld=%0d fl=%0d -> pcw=%0d iss=%0d busy=%0d sc=%0d",
             now, t.v, t.a1, t.u1, t.a2, t.u2, t.w, t.rw, t.mr, t.fl, pc_write, issue, busy, stall_count);
    @(posedge clk);
    l = lat_of(t.mr);
    if (iss_m && t.rw && t.w != 0 && l > 0 && now + l + 1 > ready[t.w]) ready[t.w] = now + l + 1;
    if (haz_m && sc_m < 15) sc_m++;
    now++;
    #1;
  endtask

  initial begin
    vec_t t;
    model_reset();
    rst_n = 1'b0; id_valid = 1'b1; flush = 1'b0;
    rd_addr_1_if_id = 5'd5; rd_addr_2_if_id = 5'd0; wr_addr_if_id = 5'd0;
    rs1_used = 1'b1; rs2_used = 1'b0; reg_write_if_id = 1'b0; mem_read_if_id = 1'b0;
    #12;
    chk("rst_pc_write", pc_write, 1);
    chk("rst_mux_sel", mux_sel, 1);
    chk("rst_issue", issue, 1);
    chk("rst_busy", busy, 0);
    chk("rst_stall_count", stall_count, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    //            v a1 a2 u1 u2 w  rw mr fl  haz busy sc
`ifdef HAZ_FORWARDING_EN
    tab.push_back(mk(1, 1, 2, 1, 1, 5, 1, 1, 0, 0, 0, 0)); // lw x5
    tab.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 1, 1, 0)); // add x6,x5,x1 stalls once
    tab.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 1)); // then issues
    tab.push_back(mk(1, 6, 0, 1, 0, 7, 1, 0, 0, 0, 0, 1)); // ALU result is forwarded
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1)); // write to x0
    tab.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1)); // reader of x0
    tab.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 1)); // lw x9
    tab.push_back(mk(1, 9, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1)); // flushed reader
    tab.push_back(mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
`else
    tab.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0)); // add x5
    tab.push_back(mk(1, 5, 2, 1, 1, 7, 1, 0, 0, 1, 1, 0)); // sub x7,x5,x2: 3 stalls
    tab.push_back(mk(1, 5, 2, 1, 1, 7, 1, 0, 0, 1, 1, 1));
    tab.push_back(mk(1, 5, 2, 1, 1, 7, 1, 0, 0, 1, 1, 2));
    tab.push_back(mk(1, 5, 2, 1, 1, 7, 1, 0, 0, 0, 0, 3));
    tab.push_back(mk(1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 3)); // x7 on unused rs2
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 3)); // write to x0
    tab.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 3)); // reader of x0
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tab.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 3)); // lw x5
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3));
    tab.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 1, 3)); // add x5: WAW reload to 3
    tab.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 1, 3));
    tab.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 1, 4));
    tab.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 1, 5));
    tab.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6));
    tab.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 6)); // add x9
    tab.push_back(mk(1, 9, 0, 1, 0, 0, 0, 0, 1, 0, 1, 6)); // flush over a hazard
    tab.push_back(mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 1, 1, 6));
`endif
    foreach (tab[i]) apply(tab[i]);

    // Asynchronous reset in the middle of a stall.
    apply(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, -1, 0, 0));
    id_valid = 1'b1; flush = 1'b0; rd_addr_1_if_id = 5'd9; rs1_used = 1'b1;
    reg_write_if_id = 1'b0; #1;
    chk("pre_rst_stall", pc_write, 0);
    rst_n = 1'b0; #1;
    chk("midrst_pc_write", pc_write, 1);
    chk("midrst_if_id_write", if_id_write, 1);
    chk("midrst_issue", issue, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_stall_count", stall_count, 0);
    model_reset();
    rst_n = 1'b1; #1;

    // Saturation of the stall counter.
`ifdef HAZ_FORWARDING_EN
    for (int k = 0; k < 22; k++) begin
`else
    for (int k = 0; k < 8; k++) begin
`endif
      apply(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, -1, 0, 0));
      for (int j = 0; j < 3; j++) apply(mk(1, 3, 0, 1, 0, 0, 0, 0, 0, -1, 0, 0));
    end
    chk("sat_stall_count", stall_count, 15);

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      t = mk($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
             1'($urandom), $urandom_range(0, 9) == 0, -1, 0, 0);
      apply(t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
